mips_mc_core: RTL and testbench

Parametrised multicycle MIPS-subset core, successor to the lab's fixed 7-bit-address CPU. It adds a configurable address width and reset vector, a ready-based memory handshake that supports wait states, an internal 32x32 register file with a debug read port, the `lui`/`slti`/`jal` instructions, and a sticky halt on illegal instructions. It sits between the top-level board wrapper and a word-addressed unified instruction/data memory.

---
 rtl/mips_mc_core.sv | 215 +++++++++++++++++++++
 tb/tb_mips_mc_core.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_mc_core.sv
// Multicycle MIPS-subset core: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer over a
// word-addressed unified memory with a ready handshake and a 32x32 register file.
module mips_mc_core #(
  parameter int AW = 7,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   MEM_RDATA,
  input  logic          MEM_RDY,
  output logic          MEM_CS,
  output logic          MEM_WE,
  output logic [AW-1:0] MEM_ADDR,
  output logic [31:0]   MEM_WDATA,
  input  logic [4:0]    DBG_SEL,
  output logic [31:0]   DBG_DATA,
  output logic [AW-1:0] PC_OUT,
  output logic          HALTED
);
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04,
                         OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_SLTI = 6'h0A, OP_ANDI = 6'h0C,
                         OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_JR = 6'h08, F_ADD = 6'h20,
                         F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26,
                         F_SLT = 6'h2A;
  localparam logic [1:0] B_REG = 2'd0, B_SEXT = 2'd1, B_ZEXT = 2'd2;
  localparam logic [AW-1:0] PC_ONE = AW'(1);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
                            ALU_SLL, ALU_SRL, ALU_LUI} alu_t;

  state_t        state_reg, state_next;
  alu_t          alu_op_reg, dec_op;
  logic [1:0]    dec_bsel;
  logic          dec_illegal;
  logic [AW-1:0] pc_reg;
  logic [31:0]   instr_reg, a_reg, b_reg, rt_reg, result_reg;
  logic [31:0]   regs [32];
  logic [31:0]   rs_val, rt_val, b_mux, alu_out, imm_sext, imm_zext, wr_data;
  logic [4:0]    wr_idx;
  logic          wr_en;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd, shamt;
  assign opcode   = instr_reg[31:26];
  assign rs       = instr_reg[25:21];
  assign rt       = instr_reg[20:16];
  assign rd       = instr_reg[15:11];
  assign shamt    = instr_reg[10:6];
  assign funct    = instr_reg[5:0];
  assign imm_sext = {{16{instr_reg[15]}}, instr_reg[15:0]};
  assign imm_zext = {16'd0, instr_reg[15:0]};

  logic is_rtype, is_jr, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, branch_taken;
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_jr    = is_rtype && (funct == F_JR);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign branch_taken = (is_beq && (a_reg == b_reg)) || (is_bne && (a_reg != b_reg));

  // r0 is never written, so reading it always yields zero.
  assign rs_val   = regs[rs];
  assign rt_val   = regs[rt];
  assign DBG_DATA = regs[DBG_SEL];
  assign PC_OUT   = pc_reg;

  always_comb begin
    dec_op      = ALU_ADD;
    dec_bsel    = B_SEXT;
    dec_illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_bsel = B_REG;
        case (funct)
          F_ADD, F_JR: dec_op = ALU_ADD;
          F_SUB:       dec_op = ALU_SUB;
          F_AND:       dec_op = ALU_AND;
          F_OR:        dec_op = ALU_OR;
          F_XOR:       dec_op = ALU_XOR;
          F_SLT:       dec_op = ALU_SLT;
          F_SLL:       dec_op = ALU_SLL;
          F_SRL:       dec_op = ALU_SRL;
          default:     dec_illegal = 1'b1;
        endcase
      end
      OP_J, OP_JAL, OP_ADDI, OP_LW, OP_SW: dec_op = ALU_ADD;
      OP_BEQ, OP_BNE: begin dec_bsel = B_REG;  dec_op = ALU_SUB; end
      OP_SLTI:        dec_op = ALU_SLT;
      OP_ANDI:  begin dec_bsel = B_ZEXT; dec_op = ALU_AND; end
      OP_ORI:   begin dec_bsel = B_ZEXT; dec_op = ALU_OR;  end
      OP_LUI:   begin dec_bsel = B_ZEXT; dec_op = ALU_LUI; end
      default:        dec_illegal = 1'b1;
    endcase
  end

  always_comb begin
    case (dec_bsel)
      B_REG:   b_mux = rt_val;
      B_ZEXT:  b_mux = imm_zext;
      default: b_mux = imm_sext;
    endcase
  end

  // Shifts operate on rt, which sits in b_reg for R-type instructions.
  always_comb begin
    case (alu_op_reg)
      ALU_SUB: alu_out = a_reg - b_reg;
      ALU_AND: alu_out = a_reg & b_reg;
      ALU_OR:  alu_out = a_reg | b_reg;
      ALU_XOR: alu_out = a_reg ^ b_reg;
      ALU_SLT: alu_out = {31'd0, $signed(a_reg) < $signed(b_reg)};
      ALU_SLL: alu_out = b_reg << shamt;
      ALU_SRL: alu_out = b_reg >> shamt;
      ALU_LUI: alu_out = {b_reg[15:0], 16'd0};
      default: alu_out = a_reg + b_reg;
    endcase
  end

  always_comb begin
    wr_en   = (state_reg == S_WB) || (state_reg == S_DECODE && is_jal);
    wr_idx  = (state_reg == S_WB) ? (is_rtype ? rd : rt) : 5'd31;
    wr_data = (state_reg == S_WB) ? result_reg : 32'(pc_reg);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en && wr_idx != 5'd0) begin
      regs[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= S_FETCH;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (MEM_RDY) state_next = S_DECODE;
      S_DECODE: begin
        if (dec_illegal)          state_next = S_HALT;
        else if (is_j || is_jal)  state_next = S_FETCH;
        else                      state_next = S_EXEC;
      end
      S_EXEC: begin
        if (is_beq || is_bne || is_jr) state_next = S_FETCH;
        else if (is_lw || is_sw)       state_next = S_MEM;
        else                           state_next = S_WB;
      end
      S_MEM:    if (MEM_RDY) state_next = is_sw ? S_FETCH : S_WB;
      S_WB:     state_next = S_FETCH;
      default:  state_next = S_HALT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_reg     <= RESET_PC;
      instr_reg  <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      rt_reg     <= '0;
      result_reg <= '0;
      alu_op_reg <= ALU_ADD;
    end else begin
      case (state_reg)
        S_FETCH: if (MEM_RDY) begin
          instr_reg <= MEM_RDATA;
          pc_reg    <= pc_reg + PC_ONE;
        end
        S_DECODE: begin
          a_reg      <= rs_val;
          b_reg      <= b_mux;
          rt_reg     <= rt_val;
          alu_op_reg <= dec_op;
          if (is_j || is_jal) pc_reg <= instr_reg[AW-1:0];
        end
        S_EXEC: begin
          result_reg <= alu_out;
          if (branch_taken) pc_reg <= pc_reg + imm_sext[AW-1:0];
          else if (is_jr)   pc_reg <= a_reg[AW-1:0];
        end
        S_MEM: if (MEM_RDY && is_lw) result_reg <= MEM_RDATA;
        default: ;
      endcase
    end
  end

  // Reset forces the bus idle so any in-flight access is abandoned.
  always_comb begin
    MEM_CS    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = (state_reg == S_MEM) ? result_reg[AW-1:0] : pc_reg;
    MEM_WDATA = '0;
    HALTED    = (state_reg == S_HALT);
    if (!RST) begin
      case (state_reg)
        S_FETCH: MEM_CS = 1'b1;
        S_MEM: begin
          MEM_CS    = 1'b1;
          MEM_WE    = is_sw;
          MEM_WDATA = is_sw ? rt_reg : 32'd0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_mc_core.sv
// Directed programs for mips_mc_core; expected bus accesses and register values
// are queued by the stimulus and compared by a negedge monitor.
module tb_mips_mc_core;
  localparam int AW = 7;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          MEM_RDY = 1'b1;
  logic [31:0]   MEM_RDATA;
  logic [4:0]    DBG_SEL = '0;
  logic          MEM_CS, MEM_WE, HALTED;
  logic [AW-1:0] MEM_ADDR, PC_OUT;
  logic [31:0]   MEM_WDATA, DBG_DATA;

  mips_mc_core #(.AW(AW), .RESET_PC(7'd5)) dut (
    .CLK(CLK), .RST(RST), .MEM_RDATA(MEM_RDATA), .MEM_RDY(MEM_RDY),
    .MEM_CS(MEM_CS), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .DBG_SEL(DBG_SEL), .DBG_DATA(DBG_DATA), .PC_OUT(PC_OUT), .HALTED(HALTED)
  );

  always #50 CLK = ~CLK;

  logic [31:0] mem [128];
  logic [31:0] img [128];
  logic        img_load = 1'b0;

  assign MEM_RDATA = mem[MEM_ADDR];
  always @(posedge CLK) begin
    if (img_load) begin
      for (int i = 0; i < 128; i++) mem[i] <= img[i];
    end else if (MEM_CS && MEM_WE && MEM_RDY && !RST) begin
      mem[MEM_ADDR] <= MEM_WDATA;
    end
  end

  logic [39:0] acc_q[$];
  string       name_q[$];
  logic [63:0] val_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        prev_wait = 1'b0;
  logic [39:0] prev_acc = '0;

  always @(negedge CLK) begin
    logic [39:0] cur;
    logic [39:0] ea;
    logic [63:0] v;
    string       n;
    cur = {MEM_WE, MEM_ADDR, MEM_WDATA};
    if (prev_wait && !RST) begin
      checks++;
      if (!MEM_CS || cur !== prev_acc) begin
        errors++;
        $display("FAIL bus_stable: act cs=%0d we/addr/wdata=%h req we/addr/wdata=%h", MEM_CS, cur, prev_acc);
      end
    end
    prev_wait = MEM_CS && !MEM_RDY && !RST;
    prev_acc  = cur;
    if (MEM_CS && MEM_RDY) begin
      checks++;
      if (acc_q.size() == 0) begin
        errors++;
        $display("FAIL access: act we=%0d addr=%0d wdata=%h req none", MEM_WE, MEM_ADDR, MEM_WDATA);
      end else begin
        ea = acc_q.pop_front();
        if (cur !== ea) begin
          errors++;
          $display("FAIL access: act we=%0d addr=%0d wdata=%h req we=%0d addr=%0d wdata=%h",
                   cur[39], cur[38:32], cur[31:0], ea[39], ea[38:32], ea[31:0]);
        end else begin
          $display("access we=%0d addr=%0d wdata=%h ok", cur[39], cur[38:32], cur[31:0]);
        end
      end
    end
    while (name_q.size() > 0) begin
      n = name_q.pop_front();
      v = val_q.pop_front();
      checks++;
      if (v[63:32] !== v[31:0]) begin
        errors++;
        $display("FAIL %s: act=%h req=%h", n, v[63:32], v[31:0]);
      end else begin
        $display("check %s = %h ok", n, v[31:0]);
      end
    end
  end

  function automatic logic [31:0] enc_r(int rs, int rt, int rd, int sh, int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(int op, int rs, int rt, logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] enc_j(int op, int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic tick();
    @(posedge CLK); #1;
  endtask
  task automatic post(string n, logic [31:0] act, logic [31:0] req);
    name_q.push_back(n);
    val_q.push_back({act, req});
  endtask
  task automatic exp_acc(logic we, int addr, logic [31:0] wd);
    acc_q.push_back({we, 7'(addr), wd});
  endtask
  task automatic dbg(int r, logic [31:0] req);
    DBG_SEL = 5'(r);
    #1;
    post($sformatf("r%0d", r), DBG_DATA, req);
  endtask
  task automatic clear_img();
    for (int i = 0; i < 128; i++) img[i] = 32'd0;
  endtask
  // Returns at the start of the first cycle after RST falls.
  task automatic start_test();
    RST = 1'b1;
    MEM_RDY = 1'b1;
    tick();
    img_load = 1'b1;
    tick();
    img_load = 1'b0;
    RST = 1'b0;
    #1;
  endtask
  // Called right after the last expected edge; reset idles the bus before the monitor samples.
  task automatic stop_test();
    post("acc_left", 32'(acc_q.size()), 32'd0);
    RST = 1'b1;
  endtask

  initial begin
    int cs_cnt;

    // Reset state plus ALU program from RESET_PC=5
    clear_img();
    img[5] = enc_i(8'h08, 0, 1, 16'hFFFD);
    img[6] = enc_i(8'h0D, 0, 2, 16'hFFFF);
    img[7] = enc_r(1, 2, 3, 0, 8'h2A);
    img[8] = enc_i(8'h0F, 0, 4, 16'h1234);
    for (int a = 5; a <= 8; a++) exp_acc(1'b0, a, 32'd0);
    start_test();
    post("rst_pc", 32'(PC_OUT), 32'd5);
    post("rst_addr", 32'(MEM_ADDR), 32'd5);
    post("rst_cs", 32'(MEM_CS), 32'd1);
    post("rst_halted", 32'(HALTED), 32'd0);
    for (int r = 0; r < 32; r++) dbg(r, 32'd0);
    repeat (16) tick();
    stop_test();
    dbg(1, 32'hFFFFFFFD);
    dbg(2, 32'h0000FFFF);
    dbg(3, 32'h00000001);
    dbg(4, 32'h12340000);

    // Remaining ALU ops, shifts, wraparound and r0 write suppression
    clear_img();
    img[5]  = enc_i(8'h08, 0, 1, 16'h0F0F);
    img[6]  = enc_i(8'h0F, 0, 2, 16'hF000);
    img[7]  = enc_r(1, 2, 3, 0, 8'h22);
    img[8]  = enc_r(1, 3, 4, 0, 8'h26);
    img[9]  = enc_r(0, 1, 5, 4, 8'h00);
    img[10] = enc_r(0, 2, 6, 28, 8'h02);
    img[11] = enc_r(1, 5, 7, 0, 8'h25);
    img[12] = enc_i(8'h0C, 3, 8, 16'h8F0F);
    img[13] = enc_i(8'h0A, 2, 9, 16'h0001);
    img[14] = enc_r(2, 2, 10, 0, 8'h20);
    img[15] = enc_i(8'h08, 0, 0, 16'h0005);
    for (int a = 5; a <= 15; a++) exp_acc(1'b0, a, 32'd0);
    start_test();
    repeat (44) tick();
    stop_test();
    dbg(0, 32'h00000000);
    dbg(3, 32'h10000F0F);
    dbg(4, 32'h10000000);
    dbg(5, 32'h0000F0F0);
    dbg(6, 32'h0000000F);
    dbg(7, 32'h0000FFFF);
    dbg(8, 32'h00000F0F);
    dbg(9, 32'h00000001);
    dbg(10, 32'hE0000000);

    // sw/lw at address 20 with 3 wait states in each MEM and 2 on the lw fetch
    clear_img();
    img[5] = enc_i(8'h08, 0, 1, 16'h5A5A);
    img[6] = enc_i(8'h2B, 0, 1, 16'd20);
    img[7] = enc_i(8'h23, 0, 2, 16'd20);
    exp_acc(1'b0, 5, 32'd0);
    exp_acc(1'b0, 6, 32'd0);
    exp_acc(1'b1, 20, 32'h00005A5A);
    exp_acc(1'b0, 7, 32'd0);
    exp_acc(1'b0, 20, 32'd0);
    start_test();
    for (int c = 1; c <= 21; c++) begin
      MEM_RDY = !(c inside {8, 9, 10, 12, 13, 17, 18, 19});
      tick();
    end
    stop_test();
    MEM_RDY = 1'b1;
    post("mem20", mem[20], 32'h00005A5A);
    dbg(2, 32'h00005A5A);

    // Jumps and branches
    clear_img();
    img[5]  = enc_i(8'h08, 0, 1, 16'h0001);
    img[6]  = enc_j(8'h02, 3);
    img[3]  = enc_j(8'h03, 40);
    img[40] = enc_i(8'h04, 1, 0, 16'h0007);
    img[41] = enc_r(31, 0, 0, 0, 8'h08);
    img[4]  = enc_j(8'h02, 10);
    img[10] = enc_i(8'h05, 1, 0, 16'hFFFF);
    exp_acc(1'b0, 5, 32'd0);
    exp_acc(1'b0, 6, 32'd0);
    exp_acc(1'b0, 3, 32'd0);
    exp_acc(1'b0, 40, 32'd0);
    exp_acc(1'b0, 41, 32'd0);
    exp_acc(1'b0, 4, 32'd0);
    exp_acc(1'b0, 10, 32'd0);
    exp_acc(1'b0, 10, 32'd0);
    start_test();
    repeat (22) tick();
    post("bne_loop_pc", 32'(PC_OUT), 32'd10);
    stop_test();
    dbg(31, 32'd4);

    // PC wraps from 127 to 0
    clear_img();
    img[5]   = enc_j(8'h02, 127);
    img[127] = enc_i(8'h08, 0, 5, 16'h0007);
    exp_acc(1'b0, 5, 32'd0);
    exp_acc(1'b0, 127, 32'd0);
    start_test();
    repeat (6) tick();
    post("wrap_pc", 32'(PC_OUT), 32'd0);
    stop_test();
    dbg(5, 32'd7);

    // Illegal opcode 0x3F halts until reset
    clear_img();
    img[5] = 32'hFC000000;
    exp_acc(1'b0, 5, 32'd0);
    start_test();
    repeat (2) tick();
    post("halted", 32'(HALTED), 32'd1);
    cs_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (MEM_CS) cs_cnt++;
      tick();
    end
    post("halt_cs", 32'(cs_cnt), 32'd0);
    post("halt_pc", 32'(PC_OUT), 32'd6);
    stop_test();
    tick();
    post("halt_clr", 32'(HALTED), 32'd0);

    // Illegal R-type funct also halts
    clear_img();
    img[5] = enc_r(1, 2, 3, 0, 8'h01);
    exp_acc(1'b0, 5, 32'd0);
    start_test();
    repeat (2) tick();
    post("halted_funct", 32'(HALTED), 32'd1);
    stop_test();

    // Reset in the middle of a stalled lw
    clear_img();
    img[5]  = enc_i(8'h23, 0, 2, 16'd20);
    img[20] = 32'hDEADBEEF;
    exp_acc(1'b0, 5, 32'd0);
    start_test();
    repeat (3) tick();
    MEM_RDY = 1'b0;
    repeat (2) tick();
    post("acc_left", 32'(acc_q.size()), 32'd0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    MEM_RDY = 1'b1;
    #1;
    post("abort_cs", 32'(MEM_CS), 32'd1);
    post("abort_addr", 32'(MEM_ADDR), 32'd5);
    post("abort_we", 32'(MEM_WE), 32'd0);
    dbg(2, 32'd0);
    RST = 1'b1;

    repeat (3) @(negedge CLK);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
